// File: rtl/fft_pkg.sv
// Shared types for the FFT input framer: frame size, read-side FSM states and
// the complex sample layout held in the ping-pong buffer.
package fft_pkg;

  localparam int N_PT = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_FEED,
    ST_WAIT
  } rd_state_t;

  typedef struct packed {
    logic [31:0] re;
    logic [31:0] im;
  } cplx_t;

endpackage

// File: rtl/fft_pingpong_buf.sv
// Two banks of N_PT complex samples with one write port and one registered
// read port; bank occupancy is tracked by the owner, not here.
module fft_pingpong_buf
  import fft_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      wr_en_i,
  input  logic                      wr_bank_i,
  input  logic [$clog2(N_PT)-1:0]   wr_addr_i,
  input  cplx_t                     wr_data_i,
  input  logic                      rd_en_i,
  input  logic                      rd_bank_i,
  input  logic [$clog2(N_PT)-1:0]   rd_addr_i,
  output cplx_t                     rd_data_o
);

  cplx_t mem_q [2][N_PT];
  cplx_t rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_bank_i][wr_addr_i] <= wr_data_i;
    end
  end

  // The read register doubles as the core-facing sample register, so it is
  // the only part of the buffer that is reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_bank_i][rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fft_in_framer.sv
// Groups a valid/ready complex sample stream into 8-sample frames and loads
// them into the FFT core. Optional s_last checking: FFT_FRAMER_LAST_CHECK_EN.
module fft_in_framer #(
  parameter int N_PT = fft_pkg::N_PT,
  parameter int DW   = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_re,
  input  logic [DW-1:0] s_im,
  input  logic          s_last,
  output logic          fft_start,
  output logic          fft_valid,
  output logic [DW-1:0] fft_re,
  output logic [DW-1:0] fft_im,
  input  logic          fft_done,
  output logic          o_busy,
  output logic          o_frame_err,
  output logic [15:0]   o_frames
);

  import fft_pkg::*;

  localparam int            AW       = $clog2(N_PT);
  localparam logic [AW-1:0] LAST_IDX = AW'(N_PT - 1);

  logic [1:0]    full_q, full_d;
  logic          wr_bank_q, wr_bank_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;

  rd_state_t     state_q;
  logic          rd_bank_q;
  logic [AW-1:0] rd_cnt_q;
  logic          start_q;
  logic          valid_q;
  logic [15:0]   frames_q;

  logic          accept;
  logic          last_bad;
  logic          release_bank;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  cplx_t         rd_data;

  assign s_ready      = !full_q[wr_bank_q];
  assign accept       = s_valid && s_ready;
  assign release_bank = (state_q == ST_WAIT) && fft_done;

`ifdef FFT_FRAMER_LAST_CHECK_EN
  logic frame_err_q;

  assign last_bad = accept && (s_last != (wr_cnt_q == LAST_IDX));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= last_bad;
    end
  end

  assign o_frame_err = frame_err_q;
`else
  logic last_unused;

  assign last_unused = s_last;
  assign last_bad    = 1'b0;
  assign o_frame_err = 1'b0;
`endif

  // Release always targets rd_bank and a fill always targets the non-full
  // wr_bank, so both updates can land on the same edge.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    wr_cnt_d  = wr_cnt_q;
    if (release_bank) begin
      full_d[rd_bank_q] = 1'b0;
    end
    if (accept) begin
      if (last_bad) begin
        wr_cnt_d = '0;
      end else if (wr_cnt_q == LAST_IDX) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_cnt_d          = '0;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      rd_bank_q <= 1'b0;
      rd_cnt_q  <= '0;
      start_q   <= 1'b0;
      valid_q   <= 1'b0;
      frames_q  <= '0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (full_q[rd_bank_q]) begin
            start_q <= 1'b1;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          rd_cnt_q <= '0;
          valid_q  <= 1'b1;
          state_q  <= ST_FEED;
        end
        ST_FEED: begin
          if (rd_cnt_q == LAST_IDX) begin
            valid_q <= 1'b0;
            state_q <= ST_WAIT;
          end else begin
            rd_cnt_q <= rd_cnt_q + 1'b1;
          end
        end
        ST_WAIT: begin
          if (fft_done) begin
            rd_bank_q <= ~rd_bank_q;
            frames_q  <= frames_q + 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Read address runs one entry ahead of rd_cnt so the registered read data
  // lines up with fft_valid.
  assign rd_en   = (state_q == ST_START) || ((state_q == ST_FEED) && (rd_cnt_q != LAST_IDX));
  assign rd_addr = (state_q == ST_START) ? '0 : rd_cnt_q + 1'b1;

  fft_pingpong_buf u_buf (
    .clk_i     (i_clk),
    .rst_i     (i_rst),
    .wr_en_i   (accept),
    .wr_bank_i (wr_bank_q),
    .wr_addr_i (wr_cnt_q),
    .wr_data_i (cplx_t'{re: s_re, im: s_im}),
    .rd_en_i   (rd_en),
    .rd_bank_i (rd_bank_q),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  assign fft_start = start_q;
  assign fft_valid = valid_q;
  assign fft_re    = rd_data.re;
  assign fft_im    = rd_data.im;
  assign o_busy    = (state_q != ST_IDLE);
  assign o_frames  = frames_q;

endmodule
